// File: rtl/seq_right_barrel_shifter_pkg.sv
// Shared constants and enums for the sequential right shifter/rotator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: WIDTH/SHW datapath sizes, STW stage-index width,
// shift_mode_t (LSR/ASR/ROR/RSVD), state_t (IDLE/SHIFT/DONE).
package shifter_pkg;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;              // log2(WIDTH)
    localparam int STW   = $clog2(SHW);    // bits needed to index a stage 0..SHW-1

    typedef enum logic [1:0] {
        LSR  = 2'b00,
        ASR  = 2'b01,
        ROR  = 2'b10,
        RSVD = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_right_barrel_shifter_rshift_stage.sv
// One logarithmic right-shift stage: shifts by 2^stage when enabled.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports: i_data (operand), i_stage (stage index, shift = 2^i_stage),
// i_en (apply shift), i_mode (LSR/ASR/ROR, RSVD acts as LSR),
// i_sign (fill bit for ASR), o_data (result).
module rshift_stage
    import shifter_pkg::*;
(
    input  logic [WIDTH-1:0] i_data,
    input  logic [STW-1:0]   i_stage,
    input  logic             i_en,
    input  shift_mode_t      i_mode,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_data
);

    logic [2*WIDTH-1:0] w_ext;
    logic [SHW-1:0]     w_shamt;

    // Extend the operand with the bits that should flow into the vacated
    // MSBs, then a single right shift of the double-width word does all modes.
    always_comb begin
        w_ext = {{WIDTH{1'b0}}, i_data};
        case (i_mode)
            ASR:     w_ext = {{WIDTH{i_sign}}, i_data};
            ROR:     w_ext = {i_data, i_data};
            default: w_ext = {{WIDTH{1'b0}}, i_data};
        endcase
    end

    assign w_shamt = SHW'(1) << i_stage;

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            o_data = WIDTH'(w_ext >> w_shamt);
        end
    end

endmodule

// File: rtl/seq_right_barrel_shifter.sv
// Multi-cycle right shifter/rotator, one log stage (8,4,2,1) per clock.
// Latency: done pulses 4 edges after the accepting edge; one result per 6 cycles.
// Backpressure: start is ignored while busy; operands are captured on acceptance.
//
// Ports: clk, rst_n (async active-low), start (request, sampled in IDLE),
// A (operand), SS (shift amount), mode (00 LSR, 01 ASR, 10 ROR, 11 as LSR),
// busy (SHIFT or DONE), done (one-cycle pulse), SSHO (last completed result).
module seq_right_barrel_shifter
    import shifter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   SS,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SSHO
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_amount;
    shift_mode_t      r_mode;
    logic [STW-1:0]   r_stage;
    logic             r_sign;
    logic [WIDTH-1:0] r_ssho;
    logic [WIDTH-1:0] w_stage_dat;

    rshift_stage u_stage (
        .i_data  (r_data),
        .i_stage (r_stage),
        .i_en    (r_amount[r_stage]),
        .i_mode  (r_mode),
        .i_sign  (r_sign),
        .o_data  (w_stage_dat)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SHIFT;
            SHIFT:   if (r_stage == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on acceptance, one stage per SHIFT cycle, stage 0 is
    // the last one and publishes its output straight into SSHO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_amount <= '0;
            r_mode   <= LSR;
            r_stage  <= '0;
            r_sign   <= 1'b0;
            r_ssho   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_data   <= A;
                        r_amount <= SS;
                        r_mode   <= shift_mode_t'(mode);
                        r_stage  <= STW'(SHW - 1);
                        r_sign   <= A[WIDTH-1];
                    end
                end
                SHIFT: begin
                    r_data <= w_stage_dat;
                    if (r_stage == '0) begin
                        r_ssho <= w_stage_dat;
                    end else begin
                        r_stage <= r_stage - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pure decodes of the state register; no input reaches an output
    // without passing through a flop.
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign SSHO = r_ssho;

endmodule

// File: tb/tb_seq_right_barrel_shifter.sv
module tb_seq_right_barrel_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [3:0]  SS;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [15:0] SSHO;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_right_barrel_shifter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .SS    (SS),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .SSHO  (SSHO)
    );

    typedef struct {
        logic [15:0] a;
        logic [3:0]  ss;
        logic [1:0]  md;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one operation, scramble the inputs after acceptance, and check
    // latency, result and the busy fall one cycle after done.
    task automatic run_op(input vec_t v, input int idx);
        int  cnt;
        bit  got;
        @(negedge clk);
        start = 1'b1; A = v.a; SS = v.ss; mode = v.md;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; A = ~v.a; SS = ~v.ss; mode = v.md ^ 2'b11;
        check($sformatf("v%0d busy_after_accept", idx), 32'(busy), 32'd1);
        cnt = 0; got = 0;
        while (cnt < 10 && !got) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            if (done) got = 1;
        end
        check($sformatf("v%0d done_latency", idx), 32'(cnt), 32'd4);
        check($sformatf("v%0d result", idx), 32'(SSHO), 32'(v.exp));
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d busy_fall", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d result_held", idx), 32'(SSHO), 32'(v.exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        int  ndone;
        logic [15:0] cap;

        vecs[0]  = '{16'h0001, 4'd0,  2'b00, 16'h0001};
        vecs[1]  = '{16'h8000, 4'd15, 2'b00, 16'h0001};
        vecs[2]  = '{16'h8000, 4'd15, 2'b01, 16'hFFFF};
        vecs[3]  = '{16'h8000, 4'd15, 2'b11, 16'h0001};
        vecs[4]  = '{16'h0001, 4'd1,  2'b10, 16'h8000};
        vecs[5]  = '{16'h0009, 4'd3,  2'b10, 16'h2001};
        vecs[6]  = '{16'h1234, 4'd8,  2'b10, 16'h3412};
        vecs[7]  = '{16'h8421, 4'd5,  2'b01, 16'hFC21};
        vecs[8]  = '{16'hABCD, 4'd12, 2'b10, 16'hBCDA};
        vecs[9]  = '{16'hFFFF, 4'd7,  2'b00, 16'h01FF};
        vecs[10] = '{16'h7FFF, 4'd15, 2'b01, 16'h0000};
        vecs[11] = '{16'h8001, 4'd15, 2'b10, 16'h0003};

        rst_n = 1'b0; start = 1'b0; A = '0; SS = '0; mode = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset SSHO", 32'(SSHO), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_op(vecs[i], i);

        // Reset in the middle of SHIFT: outputs clear immediately, no done.
        @(negedge clk);
        start = 1'b1; A = 16'h1234; SS = 4'd4; mode = 2'b00;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset SSHO", 32'(SSHO), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midreset no_done", 32'(ndone), 32'd0);
        check("midreset idle", 32'(busy), 32'd0);

        // start pulsed while busy must not disturb the running operation.
        @(negedge clk);
        start = 1'b1; A = 16'h1234; SS = 4'd4; mode = 2'b00;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; A = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0; cap = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin ndone++; cap = SSHO; end
        end
        check("busy_start done_count", 32'(ndone), 32'd1);
        check("busy_start result", 32'(cap), 32'h0123);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1; A = 16'hF000; SS = 4'd4; mode = 2'b01;
        cnt = 0;
        while (cnt < 12 && !done) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        check("b2b first_latency", 32'(cnt), 32'd5);
        check("b2b first_result", 32'(SSHO), 32'hFF00);
        @(posedge clk);
        @(negedge clk);
        check("b2b idle_gap", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b reaccept", 32'(busy), 32'd1);
        check("b2b no_done_yet", 32'(done), 32'd0);
        cnt = 0;
        while (cnt < 12 && !done) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        check("b2b second_latency", 32'(cnt), 32'd4);
        check("b2b second_result", 32'(SSHO), 32'hFF00);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
